// File: rtl/hsid_pixel_scheduler_if.sv
// ---------------------------------------------------------------------------
// hsid_pixel_scheduler_if
//
// Purpose: bundles the batch request, hsid_main control/status and result
// stream signals of the pixel scheduler into one interface.
//
// Modports:
//   master - the scheduler: drives main_start/main_clear, main configuration,
//            result_* stream and batch status; receives batch request,
//            hsid_main status and result_ready.
//   slave  - the environment (batch requester, hsid_main, result consumer).
//
// Signals:
//   batch_start, batch_abort, batch_pixels, batch_hsp_bands,
//   batch_hsp_library_size                         batch request
//   main_idle, main_done, main_error,
//   main_min_ref, main_min_mse                     hsid_main status
//   main_start, main_clear, main_hsp_bands,
//   main_hsp_library_size                          hsid_main control
//   result_valid, result_ready, result_pixel,
//   result_ref, result_mse, result_error           per-pixel result stream
//   batch_busy, batch_done, batch_error_count      batch status
// ---------------------------------------------------------------------------
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif
`ifndef HSID_WORD_WIDTH
`define HSID_WORD_WIDTH 32
`endif

interface hsid_pixel_scheduler_if #(
    parameter int HSP_BANDS_WIDTH   = `HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
    parameter int WORD_WIDTH        = `HSID_WORD_WIDTH,
    parameter int PIXEL_WIDTH       = 16
);
    logic                         batch_start;
    logic                         batch_abort;
    logic [PIXEL_WIDTH-1:0]       batch_pixels;
    logic [HSP_BANDS_WIDTH-1:0]   batch_hsp_bands;
    logic [HSP_LIBRARY_WIDTH-1:0] batch_hsp_library_size;

    logic                         main_idle;
    logic                         main_done;
    logic                         main_error;
    logic [HSP_LIBRARY_WIDTH-1:0] main_min_ref;
    logic [WORD_WIDTH-1:0]        main_min_mse;

    logic                         main_start;
    logic                         main_clear;
    logic [HSP_BANDS_WIDTH-1:0]   main_hsp_bands;
    logic [HSP_LIBRARY_WIDTH-1:0] main_hsp_library_size;

    logic                         result_valid;
    logic                         result_ready;
    logic [PIXEL_WIDTH-1:0]       result_pixel;
    logic [HSP_LIBRARY_WIDTH-1:0] result_ref;
    logic [WORD_WIDTH-1:0]        result_mse;
    logic                         result_error;

    logic                         batch_busy;
    logic                         batch_done;
    logic [PIXEL_WIDTH-1:0]       batch_error_count;

    modport master (
        input  batch_start, batch_abort, batch_pixels, batch_hsp_bands,
               batch_hsp_library_size,
        input  main_idle, main_done, main_error, main_min_ref, main_min_mse,
        output main_start, main_clear, main_hsp_bands, main_hsp_library_size,
        output result_valid, result_pixel, result_ref, result_mse, result_error,
        input  result_ready,
        output batch_busy, batch_done, batch_error_count
    );

    modport slave (
        output batch_start, batch_abort, batch_pixels, batch_hsp_bands,
               batch_hsp_library_size,
        output main_idle, main_done, main_error, main_min_ref, main_min_mse,
        input  main_start, main_clear, main_hsp_bands, main_hsp_library_size,
        input  result_valid, result_pixel, result_ref, result_mse, result_error,
        output result_ready,
        input  batch_busy, batch_done, batch_error_count
    );
endinterface

// File: rtl/hsid_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// hsid_pixel_scheduler
//
// Purpose: walks a batch of pixels through hsid_main one at a time. For each
// pixel it waits for hsid_main to be idle, pulses main_start, waits for
// main_done/main_error, then presents the best reference/MSE (or an error
// record) on a valid/ready result stream. Tracks the number of errored
// pixels and supports aborting a running batch.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - hsid_pixel_scheduler_if.master (batch request, hsid_main
//            control/status, result stream, batch status)
//
// Optional feature (macro HSID_PIXEL_SCHED_TIMEOUT_EN):
//   adds parameter TIMEOUT_CYCLES and a watchdog on the wait for hsid_main.
//   When it expires, main_clear is pulsed and the pixel is reported as an
//   error. Without the macro the scheduler waits indefinitely.
// ---------------------------------------------------------------------------
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif
`ifndef HSID_WORD_WIDTH
`define HSID_WORD_WIDTH 32
`endif

module hsid_pixel_scheduler #(
    parameter int HSP_BANDS_WIDTH   = `HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
    parameter int WORD_WIDTH        = `HSID_WORD_WIDTH,
    parameter int PIXEL_WIDTH       = 16
`ifdef HSID_PIXEL_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES    = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hsid_pixel_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        BS_IDLE,
        BS_LAUNCH,
        BS_WAIT,
        BS_EMIT,
        BS_ABORT,
        BS_DONE
    } bs_state_t;

    bs_state_t state;
    bs_state_t next_state;

    logic [PIXEL_WIDTH-1:0]       pixels_q;
    logic [HSP_BANDS_WIDTH-1:0]   bands_q;
    logic [HSP_LIBRARY_WIDTH-1:0] lib_q;
    logic [PIXEL_WIDTH-1:0]       pixel_idx;
    logic [PIXEL_WIDTH-1:0]       err_cnt;
    logic [HSP_LIBRARY_WIDTH-1:0] ref_q;
    logic [WORD_WIDTH-1:0]        mse_q;
    logic                         err_q;

    logic accept;
    logic capture_ok;
    logic capture_err;
    logic handshake;
    logic last_pixel;
    logic abort_hit;
    logic timeout_hit;
    logic main_start_c;
    logic main_clear_c;
    logic batch_done_c;

`ifdef HSID_PIXEL_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Counts cycles spent in BS_WAIT; zero on every entry because it is held
    // at zero in all other states. The watchdog fires before it can wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == BS_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // A response arriving on the expiry cycle is taken as the real answer.
    assign timeout_hit = (state == BS_WAIT) && (wd_cnt == WD_LAST) &&
                         !bus.main_done && !bus.main_error;
`else
    assign timeout_hit = 1'b0;
`endif

    assign last_pixel = (pixel_idx == pixels_q - PIXEL_WIDTH'(1));
    assign abort_hit  = bus.batch_abort && (state != BS_IDLE) && (state != BS_ABORT);

    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        capture_ok   = 1'b0;
        capture_err  = 1'b0;
        handshake    = 1'b0;
        main_start_c = 1'b0;
        main_clear_c = 1'b0;
        batch_done_c = 1'b0;

        // Abort outranks every other event, including a pending done pulse,
        // so main_start can never coincide with main_clear.
        if (abort_hit) begin
            main_clear_c = 1'b1;
            next_state   = BS_ABORT;
        end else begin
            case (state)
                BS_IDLE: begin
                    if (bus.batch_start) begin
                        accept     = 1'b1;
                        next_state = (bus.batch_pixels == '0) ? BS_DONE : BS_LAUNCH;
                    end
                end
                BS_LAUNCH: begin
                    if (bus.main_idle) begin
                        main_start_c = 1'b1;
                        next_state   = BS_WAIT;
                    end
                end
                BS_WAIT: begin
                    if (bus.main_error || timeout_hit) begin
                        capture_err  = 1'b1;
                        main_clear_c = timeout_hit;
                        next_state   = BS_EMIT;
                    end else if (bus.main_done) begin
                        capture_ok = 1'b1;
                        next_state = BS_EMIT;
                    end
                end
                BS_EMIT: begin
                    if (bus.result_ready) begin
                        handshake  = 1'b1;
                        next_state = last_pixel ? BS_DONE : BS_LAUNCH;
                    end
                end
                BS_ABORT: begin
                    if (bus.main_idle) begin
                        next_state = BS_IDLE;
                    end
                end
                BS_DONE: begin
                    batch_done_c = 1'b1;
                    next_state   = BS_IDLE;
                end
                default: next_state = BS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BS_IDLE;
            pixels_q  <= '0;
            bands_q   <= '0;
            lib_q     <= '0;
            pixel_idx <= '0;
            err_cnt   <= '0;
            ref_q     <= '0;
            mse_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                pixels_q  <= bus.batch_pixels;
                bands_q   <= bus.batch_hsp_bands;
                lib_q     <= bus.batch_hsp_library_size;
                pixel_idx <= '0;
                err_cnt   <= '0;
            end
            if (capture_ok) begin
                ref_q <= bus.main_min_ref;
                mse_q <= bus.main_min_mse;
                err_q <= 1'b0;
            end
            if (capture_err) begin
                ref_q <= '0;
                mse_q <= '0;
                err_q <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
            if (handshake && !last_pixel) begin
                pixel_idx <= pixel_idx + 1'b1;
            end
        end
    end

    assign bus.main_start            = main_start_c;
    assign bus.main_clear            = main_clear_c;
    assign bus.main_hsp_bands        = bands_q;
    assign bus.main_hsp_library_size = lib_q;
    assign bus.result_valid          = (state == BS_EMIT);
    assign bus.result_pixel          = pixel_idx;
    assign bus.result_ref            = ref_q;
    assign bus.result_mse            = mse_q;
    assign bus.result_error          = err_q;
    assign bus.batch_busy            = (state != BS_IDLE);
    assign bus.batch_done            = batch_done_c;
    assign bus.batch_error_count     = err_cnt;

endmodule

// File: tb/tb_hsid_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hsid_pixel_scheduler
//
// Drives batches with random sizes, random hsid_main latencies/outcomes,
// random result back-pressure and occasional aborts. A behavioural hsid_main
// stand-in decides each pixel's outcome, from which the expected result
// record, error count and pulse counts are derived.
// ---------------------------------------------------------------------------
module tb_hsid_pixel_scheduler;
    localparam int BW = 8;
    localparam int LW = 6;
    localparam int WW = 20;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hsid_pixel_scheduler_if #(
        .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW),
        .WORD_WIDTH(WW), .PIXEL_WIDTH(PW)
    ) bus ();

    hsid_pixel_scheduler #(
        .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW),
        .WORD_WIDTH(WW), .PIXEL_WIDTH(PW)
`ifdef HSID_PIXEL_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_start = 0;
    int cnt_clear = 0;
    int cnt_done  = 0;
    int force_stall   = -1;
    int force_outcome = -1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Let combinational outputs settle after this cycle's inputs, then
    // tally the control pulses seen in this cycle.
    task automatic settle();
        #1;
        if (bus.main_start === 1'b1) cnt_start++;
        if (bus.main_clear === 1'b1) cnt_clear++;
        if (bus.batch_done === 1'b1) cnt_done++;
        if (bus.main_start === 1'b1 || bus.main_clear === 1'b1)
            chk_eq("start_clear_excl", 64'(bus.main_start & bus.main_clear), 64'(0));
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic check_result(input int p, input logic [LW-1:0] eref,
                                input logic [WW-1:0] emse, input logic eerr);
        chk_eq("result_valid", 64'(bus.result_valid), 64'(1));
        chk_eq("result_pixel", 64'(bus.result_pixel), 64'(p));
        chk_eq("result_ref",   64'(bus.result_ref),   64'(eref));
        chk_eq("result_mse",   64'(bus.result_mse),   64'(emse));
        chk_eq("result_error", 64'(bus.result_error), 64'(eerr));
    endtask

    task automatic run_batch(input int npix, input int abort_pix);
        logic [BW-1:0] bands;
        logic [LW-1:0] lib;
        logic [LW-1:0] rref;
        logic [WW-1:0] rmse;
        logic [LW-1:0] exp_ref;
        logic [WW-1:0] exp_mse;
        logic          exp_err;
        int starts0, done0, clr0, exp_errs, k, lat, outcome, stall;
        bit got;
        bands    = BW'($urandom);
        lib      = LW'($urandom);
        starts0  = cnt_start;
        done0    = cnt_done;
        clr0     = cnt_clear;
        exp_errs = 0;

        bus.batch_pixels           = PW'(npix);
        bus.batch_hsp_bands        = bands;
        bus.batch_hsp_library_size = lib;
        bus.batch_start            = 1'b1;
        bus.main_idle              = 1'b1;
        settle();
        chk_eq("busy_before_accept", 64'(bus.batch_busy), 64'(0));
        advance();
        // Scramble the request inputs to show the accepted values are held.
        bus.batch_start            = 1'b0;
        bus.batch_pixels           = PW'($urandom);
        bus.batch_hsp_bands        = BW'($urandom);
        bus.batch_hsp_library_size = LW'($urandom);

        if (npix == 0) begin
            settle();
            chk_eq("empty_done",  64'(bus.batch_done),   64'(1));
            chk_eq("empty_busy",  64'(bus.batch_busy),   64'(1));
            chk_eq("empty_valid", 64'(bus.result_valid), 64'(0));
            advance();
            settle();
            chk_eq("empty_done_end", 64'(bus.batch_done), 64'(0));
            chk_eq("empty_idle",     64'(bus.batch_busy), 64'(0));
            chk_eq("empty_starts",   64'(cnt_start - starts0), 64'(0));
            advance();
            return;
        end

        for (int p = 0; p < npix; p++) begin
            k = $urandom_range(0, 2);
            bus.main_idle = 1'b0;
            for (int i = 0; i < k; i++) begin
                settle();
                chk_eq("no_start_main_busy", 64'(bus.main_start), 64'(0));
                advance();
            end
            bus.main_idle = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 4 && !got; i++) begin
                settle();
                if (bus.main_start === 1'b1) got = 1'b1;
                else advance();
            end
            chk_eq("main_start_seen", 64'(got), 64'(1));
            if (!got) return;
            chk_eq("cfg_bands", 64'(bus.main_hsp_bands),        64'(bands));
            chk_eq("cfg_lib",   64'(bus.main_hsp_library_size), 64'(lib));
            advance();
            bus.main_idle = 1'b0;

            if (p == abort_pix) begin
                for (int i = 0; i < 2; i++) begin
                    settle();
                    advance();
                end
                bus.batch_abort = 1'b1;
                bus.main_done   = 1'($urandom_range(0, 1));
                settle();
                chk_eq("abort_clear", 64'(bus.main_clear), 64'(1));
                chk_eq("abort_start", 64'(bus.main_start), 64'(0));
                advance();
                bus.batch_abort = 1'b0;
                bus.main_done   = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    settle();
                    chk_eq("abort_valid", 64'(bus.result_valid), 64'(0));
                    chk_eq("abort_busy",  64'(bus.batch_busy),   64'(1));
                    advance();
                end
                bus.main_idle = 1'b1;
                settle();
                chk_eq("abort_busy_last", 64'(bus.batch_busy), 64'(1));
                advance();
                settle();
                chk_eq("abort_idle",     64'(bus.batch_busy),       64'(0));
                chk_eq("abort_clears",   64'(cnt_clear - clr0),     64'(1));
                chk_eq("abort_no_done",  64'(cnt_done - done0),     64'(0));
                chk_eq("abort_starts",   64'(cnt_start - starts0),  64'(p + 1));
                advance();
                return;
            end

            lat = $urandom_range(1, 12);
            outcome = (force_outcome >= 0 && p == npix - 1) ? force_outcome : int'($urandom_range(0, 3));
            for (int i = 0; i < lat - 1; i++) begin
                settle();
                chk_eq("valid_in_wait", 64'(bus.result_valid), 64'(0));
                advance();
            end
            rref = LW'($urandom);
            rmse = WW'($urandom);
            bus.main_min_ref = rref;
            bus.main_min_mse = rmse;
            bus.main_done    = (outcome != 2);
            bus.main_error   = (outcome >= 2);
            settle();
            advance();
            bus.main_done    = 1'b0;
            bus.main_error   = 1'b0;
            bus.main_idle    = 1'b1;
            bus.main_min_ref = LW'($urandom);
            bus.main_min_mse = WW'($urandom);

            exp_err = (outcome >= 2);
            exp_ref = exp_err ? '0 : rref;
            exp_mse = exp_err ? '0 : rmse;
            if (exp_err) exp_errs++;

            stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
            bus.result_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                settle();
                check_result(p, exp_ref, exp_mse, exp_err);
                chk_eq("no_start_in_emit", 64'(bus.main_start), 64'(0));
                advance();
            end
            bus.result_ready = 1'b1;
            settle();
            check_result(p, exp_ref, exp_mse, exp_err);
            advance();
            bus.result_ready = 1'b0;
        end

        settle();
        chk_eq("batch_done",      64'(bus.batch_done),        64'(1));
        chk_eq("error_count",     64'(bus.batch_error_count), 64'(exp_errs));
        chk_eq("busy_in_done",    64'(bus.batch_busy),        64'(1));
        advance();
        settle();
        chk_eq("batch_done_end",  64'(bus.batch_done),        64'(0));
        chk_eq("idle_after_done", 64'(bus.batch_busy),        64'(0));
        chk_eq("start_pulses",    64'(cnt_start - starts0),   64'(npix));
        chk_eq("done_pulses",     64'(cnt_done - done0),      64'(1));
        advance();
    endtask

    int  npix_r;
    int  abort_r;
    int  wait_n;
    bit  got_clear;

    initial begin
        bus.batch_start            = 1'b1;
        bus.batch_abort            = 1'b1;
        bus.batch_pixels           = 16'd3;
        bus.batch_hsp_bands        = '1;
        bus.batch_hsp_library_size = '1;
        bus.main_idle              = 1'b1;
        bus.main_done              = 1'b1;
        bus.main_error             = 1'b0;
        bus.main_min_ref           = '1;
        bus.main_min_mse           = '1;
        bus.result_ready           = 1'b1;
        rst_n                      = 1'b0;
        advance();
        advance();
        settle();
        chk_eq("rst_main_start",  64'(bus.main_start),            64'(0));
        chk_eq("rst_main_clear",  64'(bus.main_clear),            64'(0));
        chk_eq("rst_valid",       64'(bus.result_valid),          64'(0));
        chk_eq("rst_busy",        64'(bus.batch_busy),            64'(0));
        chk_eq("rst_done",        64'(bus.batch_done),            64'(0));
        chk_eq("rst_err_count",   64'(bus.batch_error_count),     64'(0));
        chk_eq("rst_bands",       64'(bus.main_hsp_bands),        64'(0));
        chk_eq("rst_lib",         64'(bus.main_hsp_library_size), 64'(0));
        chk_eq("rst_result",      64'({bus.result_ref, bus.result_mse, bus.result_error}), 64'(0));
        bus.batch_start  = 1'b0;
        bus.batch_abort  = 1'b0;
        bus.main_done    = 1'b0;
        bus.result_ready = 1'b0;
        advance();
        rst_n = 1'b1;
        advance();

        // Three pixels with a long back-pressure stall on each result.
        force_stall = 5;
        run_batch(3, -1);
        force_stall = -1;
        // Last pixel sees main_done and main_error together.
        force_outcome = 3;
        run_batch(2, -1);
        force_outcome = -1;
        run_batch(0, -1);
        run_batch(3, 1);

        for (int b = 0; b < 16; b++) begin
            npix_r  = $urandom_range(0, 5);
            abort_r = -1;
            if (npix_r > 0 && $urandom_range(0, 3) == 0)
                abort_r = $urandom_range(0, npix_r - 1);
            run_batch(npix_r, abort_r);
        end

        // Reset in the middle of a batch: abandoned at once, no main_clear.
        bus.batch_pixels    = 16'd2;
        bus.batch_hsp_bands = 8'h5a;
        bus.batch_start     = 1'b1;
        bus.main_idle       = 1'b1;
        settle();
        advance();
        bus.batch_start = 1'b0;
        settle();
        chk_eq("mid_rst_start", 64'(bus.main_start), 64'(1));
        advance();
        bus.main_idle = 1'b0;
        settle();
        advance();
        rst_n = 1'b0;
        settle();
        chk_eq("mid_rst_busy",  64'(bus.batch_busy),     64'(0));
        chk_eq("mid_rst_clear", 64'(bus.main_clear),     64'(0));
        chk_eq("mid_rst_bands", 64'(bus.main_hsp_bands), 64'(0));
        advance();
        rst_n = 1'b1;
        bus.main_idle = 1'b1;
        advance();
        run_batch(2, -1);

`ifdef HSID_PIXEL_SCHED_TIMEOUT_EN
        // hsid_main never answers: watchdog clears it and reports an error.
        bus.batch_pixels = 16'd1;
        bus.batch_start  = 1'b1;
        settle();
        advance();
        bus.batch_start = 1'b0;
        settle();
        chk_eq("to_start", 64'(bus.main_start), 64'(1));
        advance();
        bus.main_idle = 1'b0;
        wait_n    = 0;
        got_clear = 1'b0;
        for (int i = 0; i < 40 && !got_clear; i++) begin
            settle();
            if (bus.main_clear === 1'b1) got_clear = 1'b1;
            else begin
                wait_n++;
                advance();
            end
        end
        chk_eq("to_clear_seen", 64'(got_clear), 64'(1));
        chk_eq("to_wait_cycles", 64'(wait_n + 1), 64'(16));
        advance();
        bus.main_idle    = 1'b1;
        bus.result_ready = 1'b1;
        settle();
        check_result(0, '0, '0, 1'b1);
        advance();
        bus.result_ready = 1'b0;
        settle();
        chk_eq("to_done",      64'(bus.batch_done),        64'(1));
        chk_eq("to_err_count", 64'(bus.batch_error_count), 64'(1));
        advance();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
